// File: rtl/pf_lanectrl_pause_sync_multi.sv
// Multi-lane HS_IO_CLK_PAUSE synchroniser with optional pulse stretch and gap FSM.
// Optional PF_LANECTRL_PAUSE_SYNC_FALL_EN retimes the outputs onto falling CLK edges.
module pf_lanectrl_pause_sync_multi #(
   parameter int NUM_LANES   = 4,
   parameter int SYNC_STAGES = 2,
   parameter int MIN_PULSE   = 3,
   parameter int MIN_GAP     = 1,
   parameter int MODE        = 2
) (
   input  logic                 CLK,
   input  logic                 RESET,
   input  logic [NUM_LANES-1:0] HS_IO_CLK_PAUSE,
   output logic [NUM_LANES-1:0] HS_IO_CLK_PAUSE_SYNC,
   output logic                 PAUSE_ANY
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ASSERT = 2'd1,
      S_GAP    = 2'd2
   } state_e;

   localparam logic [3:0] PULSE_LD = 4'(MIN_PULSE - 1);
   localparam logic [3:0] GAP_LD   = (MIN_GAP == 0) ? 4'd0 : 4'(MIN_GAP - 1);

   if ((NUM_LANES < 1) || (NUM_LANES > 16)) begin : g_bad_lanes
      $error("NUM_LANES out of range 1..16");
   end
   if ((SYNC_STAGES < 1) || (SYNC_STAGES > 4)) begin : g_bad_sync
      $error("SYNC_STAGES out of range 1..4");
   end
   if ((MIN_PULSE < 1) || (MIN_PULSE > 15)) begin : g_bad_pulse
      $error("MIN_PULSE out of range 1..15");
   end
   if ((MIN_GAP < 0) || (MIN_GAP > 15)) begin : g_bad_gap
      $error("MIN_GAP out of range 0..15");
   end
   if ((MODE < 0) || (MODE > 2)) begin : g_bad_mode
      $error("MODE out of range 0..2");
   end

   if (MODE == 0) begin : g_feed
      assign HS_IO_CLK_PAUSE_SYNC = HS_IO_CLK_PAUSE;
   end else begin : g_sync
      for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
         logic [SYNC_STAGES-1:0] sync_q;
         logic [SYNC_STAGES-1:0] sync_d;
         logic                   s;
         logic                   out_q;
         logic                   out_d;
         logic                   lane_out;

         always_comb begin
            sync_d    = sync_q << 1;
            sync_d[0] = HS_IO_CLK_PAUSE[g];
         end

         assign s = sync_q[SYNC_STAGES-1];

         always_ff @(posedge CLK or posedge RESET) begin
            if (RESET) begin
               sync_q <= '0;
               out_q  <= 1'b0;
            end else begin
               sync_q <= sync_d;
               out_q  <= out_d;
            end
         end

         if (MODE == 1) begin : g_flop
            assign out_d = s;
         end else begin : g_fsm
            state_e     state_q;
            state_e     state_d;
            logic [3:0] cnt_q;
            logic [3:0] cnt_d;
            logic [3:0] gcnt_q;
            logic [3:0] gcnt_d;
            logic       pend_q;
            logic       pend_d;

            always_ff @(posedge CLK or posedge RESET) begin
               if (RESET) begin
                  state_q <= S_IDLE;
                  cnt_q   <= 4'd0;
                  gcnt_q  <= 4'd0;
                  pend_q  <= 1'b0;
               end else begin
                  state_q <= state_d;
                  cnt_q   <= cnt_d;
                  gcnt_q  <= gcnt_d;
                  pend_q  <= pend_d;
               end
            end

            // pend_q remembers a request that arrives while the gap is still counting
            always_comb begin
               state_d = state_q;
               cnt_d   = cnt_q;
               gcnt_d  = gcnt_q;
               pend_d  = pend_q;
               unique case (state_q)
                  S_IDLE: begin
                     if (s) begin
                        state_d = S_ASSERT;
                        cnt_d   = PULSE_LD;
                     end
                  end
                  S_ASSERT: begin
                     if (cnt_q != 4'd0) begin
                        cnt_d = cnt_q - 4'd1;
                     end else if (!s) begin
                        if (MIN_GAP == 0) begin
                           state_d = S_IDLE;
                        end else begin
                           state_d = S_GAP;
                           gcnt_d  = GAP_LD;
                           pend_d  = 1'b0;
                        end
                     end
                  end
                  S_GAP: begin
                     if (s) begin
                        pend_d = 1'b1;
                     end
                     if (gcnt_q != 4'd0) begin
                        gcnt_d = gcnt_q - 4'd1;
                     end else if (s || pend_q) begin
                        state_d = S_ASSERT;
                        cnt_d   = PULSE_LD;
                        pend_d  = 1'b0;
                     end else begin
                        state_d = S_IDLE;
                     end
                  end
                  default: begin
                     state_d = S_IDLE;
                  end
               endcase
            end

            assign out_d = (state_d == S_ASSERT);
         end

`ifdef PF_LANECTRL_PAUSE_SYNC_FALL_EN
         logic fall_q;

         always_ff @(negedge CLK or posedge RESET) begin
            if (RESET) begin
               fall_q <= 1'b0;
            end else begin
               fall_q <= out_q;
            end
         end

         assign lane_out = fall_q;
`else
         assign lane_out = out_q;
`endif

         assign HS_IO_CLK_PAUSE_SYNC[g] = lane_out;
      end
   end

   assign PAUSE_ANY = |HS_IO_CLK_PAUSE_SYNC;

endmodule

// File: tb/tb_pf_lanectrl_pause_sync_multi.sv
// Directed scoreboard bench for pf_lanectrl_pause_sync_multi (default, MODE0, MODE1, SYNC4).
// Samples 6ns after each rising edge so rise- and fall-edge builds read the same values.
module tb_pf_lanectrl_pause_sync_multi;

   logic       CLK;
   logic       RESET;
   logic [3:0] pin;
   logic [3:0] o_d;
   logic       any_d;
   logic [3:0] o_m0;
   logic       any_m0;
   logic [3:0] o_m1;
   logic       any_m1;
   logic [3:0] o_s4;
   logic       any_s4;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic [3:0] in;
      logic [3:0] d;
      logic [3:0] m1;
      logic [3:0] s4;
   } step_t;

   step_t sb_q[$];

   pf_lanectrl_pause_sync_multi u_dut (
      .CLK(CLK), .RESET(RESET), .HS_IO_CLK_PAUSE(pin),
      .HS_IO_CLK_PAUSE_SYNC(o_d), .PAUSE_ANY(any_d)
   );

   pf_lanectrl_pause_sync_multi #(.MODE(0)) u_m0 (
      .CLK(CLK), .RESET(RESET), .HS_IO_CLK_PAUSE(pin),
      .HS_IO_CLK_PAUSE_SYNC(o_m0), .PAUSE_ANY(any_m0)
   );

   pf_lanectrl_pause_sync_multi #(.MODE(1)) u_m1 (
      .CLK(CLK), .RESET(RESET), .HS_IO_CLK_PAUSE(pin),
      .HS_IO_CLK_PAUSE_SYNC(o_m1), .PAUSE_ANY(any_m1)
   );

   pf_lanectrl_pause_sync_multi #(.SYNC_STAGES(4), .MODE(2)) u_s4 (
      .CLK(CLK), .RESET(RESET), .HS_IO_CLK_PAUSE(pin),
      .HS_IO_CLK_PAUSE_SYNC(o_s4), .PAUSE_ANY(any_s4)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   function automatic logic rng(input int k, input int a, input int b);
      return (k >= a) && (k <= b);
   endfunction

   task automatic chk(input string tag, input logic [3:0] obs,
                      input logic [3:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [3:0] in, input logic [3:0] d,
                       input logic [3:0] m1, input logic [3:0] s4);
      step_t st;
      st.in = in;
      st.d  = d;
      st.m1 = m1;
      st.s4 = s4;
      sb_q.push_back(st);
   endtask

   task automatic play(input string tag);
      step_t st;
      int    k;
      k = 1;
      while (sb_q.size() != 0) begin
         st  = sb_q.pop_front();
         pin = st.in;
         @(posedge CLK);
         #6;
         chk($sformatf("%s_e%0d_out", tag, k), o_d, st.d);
         chk($sformatf("%s_e%0d_any", tag, k), {3'b0, any_d}, {3'b0, |st.d});
         chk($sformatf("%s_e%0d_m0", tag, k), o_m0, st.in);
         chk($sformatf("%s_e%0d_m0any", tag, k), {3'b0, any_m0}, {3'b0, |st.in});
         chk($sformatf("%s_e%0d_m1", tag, k), o_m1, st.m1);
         chk($sformatf("%s_e%0d_s4", tag, k), o_s4, st.s4);
         k++;
      end
   endtask

   initial begin
      RESET = 1'b1;
      pin   = 4'b0;
      #12;
      chk("rst_out", o_d, 4'b0);
      chk("rst_any", {3'b0, any_d}, 4'b0);
      chk("rst_m1", o_m1, 4'b0);
      chk("rst_s4", o_s4, 4'b0);
      RESET = 1'b0;

      // lane0 single-cycle pulse: stretched to 3 cycles
      for (int k = 1; k <= 10; k++)
         push({3'b0, k == 1},
              {3'b0, rng(k, 3, 5)},
              {3'b0, k == 3},
              {3'b0, rng(k, 5, 7)});
      play("p1");

      // lane2 held 10 cycles: width preserved
      for (int k = 1; k <= 16; k++)
         push({1'b0, rng(k, 1, 10), 2'b0},
              {1'b0, rng(k, 3, 12), 2'b0},
              {1'b0, rng(k, 3, 12), 2'b0},
              {1'b0, rng(k, 5, 14), 2'b0});
      play("held");

      // lane1 two pulses, second seen during GAP
      for (int k = 1; k <= 14; k++)
         push({2'b0, (k == 1) || (k == 5), 1'b0},
              {2'b0, rng(k, 3, 5) || rng(k, 7, 9), 1'b0},
              {2'b0, (k == 3) || (k == 7), 1'b0},
              {2'b0, rng(k, 5, 7) || rng(k, 9, 11), 1'b0});
      play("gap");

      // simultaneous lanes: 0/3 short, 1 held 5 cycles
      for (int k = 1; k <= 12; k++)
         push({k == 1, 1'b0, rng(k, 1, 5), k == 1},
              {rng(k, 3, 5), 1'b0, rng(k, 3, 7), rng(k, 3, 5)},
              {k == 3, 1'b0, rng(k, 3, 7), k == 3},
              {rng(k, 5, 7), 1'b0, rng(k, 5, 9), rng(k, 5, 7)});
      play("multi");

      // lane3 held, reset mid-pulse
      for (int k = 1; k <= 4; k++)
         push(4'b1000,
              {rng(k, 3, 4), 3'b0},
              {rng(k, 3, 4), 3'b0},
              4'b0);
      play("pre_rst");
      RESET = 1'b1;
      #1;
      chk("rst_mid_out", o_d, 4'b0);
      chk("rst_mid_any", {3'b0, any_d}, 4'b0);
      chk("rst_mid_m1", o_m1, 4'b0);
      @(posedge CLK);
      #6;
      chk("rst_hold_out", o_d, 4'b0);
      RESET = 1'b0;
      for (int k = 1; k <= 6; k++)
         push(4'b1000,
              {k >= 3, 3'b0},
              {k >= 3, 3'b0},
              {k >= 5, 3'b0});
      play("post_rst");

      pin = 4'b0;
      for (int k = 1; k <= 8; k++)
         push(4'b0,
              {rng(k, 1, 2), 3'b0},
              {rng(k, 1, 2), 3'b0},
              {rng(k, 1, 4), 3'b0});
      play("release");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
